// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - arbitrates handshake/data packets onto the USB TX engine.
// Optional single retry of failed data packets when USB_TX_RETRY_EN is defined.
module usb_tx_scheduler #(
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_SIZE      = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [1:0] hs_pid,
  output logic       hs_grant,
  input  logic       data_req,
  input  logic [6:0] data_size,
  output logic       data_grant,
  output logic       data_done,
  output logic       data_err,
  input  logic       ack_rcvd,
  input  logic       toggle_clr,
  output logic [2:0] tx_packet,
  output logic [6:0] tx_packet_size,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic       busy,
  output logic       data_toggle
);

`ifdef USB_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [6:0] MAX_SZ = 7'(MAX_SIZE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, GAP} state_t;

  state_t        state_q, state_d;
  logic          is_data_q, is_data_d;
  logic [2:0]    hs_cmd_q, hs_cmd_d;
  logic [6:0]    dsize_q, dsize_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic          toggle_q, toggle_d;
  logic          pkt_tog_q, pkt_tog_d;
  logic          done_q, done_d;
  logic          derr_q, derr_d;
  logic          retry_pend_q, retry_pend_d;
  logic          retry_act_q, retry_act_d;

  logic       hs_grant_c, data_grant_c, rej_err_c, fail_c, eff_tog;
  logic [2:0] tx_pkt_c;

  // A retry must resend the exact toggle of the failed attempt.
  assign eff_tog = (RETRY_EN && retry_act_q) ? pkt_tog_q : toggle_q;

  always_comb begin
    state_d      = state_q;
    is_data_d    = is_data_q;
    hs_cmd_d     = hs_cmd_q;
    dsize_d      = dsize_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    err_d        = err_q;
    pkt_tog_d    = pkt_tog_q;
    retry_pend_d = retry_pend_q;
    retry_act_d  = retry_act_q;
    done_d       = 1'b0;
    derr_d       = 1'b0;
    hs_grant_c   = 1'b0;
    data_grant_c = 1'b0;
    rej_err_c    = 1'b0;
    fail_c       = 1'b0;
    tx_pkt_c     = 3'd0;

    if (toggle_clr)    toggle_d = 1'b0;
    else if (ack_rcvd) toggle_d = ~toggle_q;
    else               toggle_d = toggle_q;

    case (state_q)
      IDLE: begin
        if (hs_req) begin
          if (hs_pid == 2'd3) begin
            rej_err_c = 1'b1;
          end else begin
            hs_grant_c = 1'b1;
            is_data_d  = 1'b0;
            hs_cmd_d   = 3'd3 + {1'b0, hs_pid};
            state_d    = ISSUE;
          end
        end else if (retry_pend_q) begin
          is_data_d    = 1'b1;
          retry_pend_d = 1'b0;
          retry_act_d  = 1'b1;
          state_d      = ISSUE;
        end else if (data_req) begin
          if (data_size > MAX_SZ) begin
            rej_err_c = 1'b1;
          end else begin
            data_grant_c = 1'b1;
            is_data_d    = 1'b1;
            dsize_d      = data_size;
            retry_act_d  = 1'b0;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        tx_pkt_c  = is_data_q ? (eff_tog ? 3'd2 : 3'd1) : hs_cmd_q;
        pkt_tog_d = eff_tog;
        timer_d   = TW'(1);
        err_d     = 1'b0;
        state_d   = WAIT_START;
      end
      WAIT_START: begin
        if (tx_transfer_active) begin
          err_d   = tx_error;
          state_d = ACTIVE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          fail_c  = is_data_q;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ACTIVE: begin
        if (tx_transfer_active) begin
          err_d = err_q | tx_error;
        end else begin
          if (is_data_q) begin
            fail_c = err_q | tx_error;
            done_d = ~(err_q | tx_error);
          end
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (fail_c) begin
      if (RETRY_EN && !retry_act_q) retry_pend_d = 1'b1;
      else                          derr_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= IDLE;
      is_data_q    <= 1'b0;
      hs_cmd_q     <= 3'd0;
      dsize_q      <= 7'd0;
      timer_q      <= '0;
      gap_q        <= '0;
      err_q        <= 1'b0;
      toggle_q     <= 1'b0;
      pkt_tog_q    <= 1'b0;
      done_q       <= 1'b0;
      derr_q       <= 1'b0;
      retry_pend_q <= 1'b0;
      retry_act_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_data_q    <= is_data_d;
      hs_cmd_q     <= hs_cmd_d;
      dsize_q      <= dsize_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      err_q        <= err_d;
      toggle_q     <= toggle_d;
      pkt_tog_q    <= pkt_tog_d;
      done_q       <= done_d;
      derr_q       <= derr_d;
      retry_pend_q <= retry_pend_d;
      retry_act_q  <= retry_act_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the state register clears.
  assign hs_grant       = ~n_rst & hs_grant_c;
  assign data_grant     = ~n_rst & data_grant_c;
  assign data_err       = ~n_rst & (rej_err_c | derr_q);
  assign data_done      = ~n_rst & done_q;
  assign tx_packet      = n_rst ? 3'd0 : tx_pkt_c;
  assign busy           = ~n_rst & (state_q != IDLE);
  assign tx_packet_size = (busy && is_data_q) ? dsize_q : 7'd0;
  assign data_toggle    = ~n_rst & toggle_q;

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Sequences the USB TX packet engine and shares it between two requesters: a handshake requester (ACK/NAK/STALL from the protocol FSM) and a data requester (DATA0/DATA1 payload from the endpoint buffer).
- Arbitrates between the two and drives the engine's tx_packet command and tx_packet_size.
- Tracks the engine's tx_transfer_active and tx_error.
- Enforces an inter-packet gap and maintains the endpoint data toggle.
- Sits between the endpoint protocol logic and the TX engine, all in the system clock domain.

Parameters:
GAP_CYCLES, 16, idle cycles enforced after tx_transfer_active falls before the next command.
START_TIMEOUT, 64, cycles allowed from command issue to tx_transfer_active rising.
MAX_SIZE, 64, largest legal data payload in bytes.

Ports:
clk  in  1  system clock.
n_rst  in  1  reset, synchronous, active-high (1 = reset); the name follows the codebase port name only.
hs_req  in  1  handshake request, level, held until hs_grant.
hs_pid  in  2  0=ACK, 1=NAK, 2=STALL, 3=reserved.
hs_grant  out  1  one-cycle pulse when the handshake command is issued.
data_req  in  1  data request, level, held until data_grant.
data_size  in  7  payload byte count, sampled on data_grant.
data_grant  out  1  one-cycle pulse when the data command is issued.
data_done  out  1  one-cycle pulse when the data packet completes without error.
data_err  out  1  one-cycle pulse on a rejected request, a timeout, or a tx_error during data.
ack_rcvd  in  1  host ACKed the last data packet; flips the toggle.
toggle_clr  in  1  forces the toggle to DATA0 (SETUP/config).
tx_packet  out  3  engine command: 0=IDLE, 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL.
tx_packet_size  out  7  payload size to the engine.
tx_transfer_active  in  1  engine busy.
tx_error  in  1  engine error.
busy  out  1  high in every state except IDLE.
data_toggle  out  1  0=DATA0 next, 1=DATA1 next.

Behaviour:
Reset values (while n_rst=1):
- All outputs 0; tx_packet=IDLE; FSM in IDLE; timers cleared; data_toggle=0.

FSM states: IDLE, ISSUE, WAIT_START, ACTIVE, GAP.

IDLE:
- hs_req has strict priority over data_req.
- hs_pid=3: pulse data_err and drop the request; stay IDLE. The requester must deassert.
- data_req with data_size>MAX_SIZE: pulse data_err, no grant, stay IDLE.
- data_size=0 is legal (zero-length packet).
- Otherwise latch the command and size, pulse the matching grant, go to ISSUE.

ISSUE:
- tx_packet holds the command for exactly 1 cycle; tx_packet_size holds the size until GAP exits.
- Data packets use 1+data_toggle; handshakes use tx_packet_size=0.
- Next state WAIT_START; the start timer is cleared.

WAIT_START:
- tx_packet=IDLE.
- tx_transfer_active=1 → ACTIVE.
- Timer reaches START_TIMEOUT (counting from ISSUE) → GAP; pulse data_err if the command was a data packet.

ACTIVE:
- tx_error=1 seen in any cycle is latched.
- tx_transfer_active falls: latched error on data → pulse data_err; clean data → pulse data_done. Go to GAP.
- Errors on handshake packets are ignored.

GAP:
- Count GAP_CYCLES cycles, then return to IDLE.
- Requests are not sampled in GAP; the earliest next grant is in the IDLE cycle after the gap.

Toggle:
- ack_rcvd flips data_toggle in any state.
- toggle_clr forces 0 and wins over ack_rcvd in the same cycle.
- The toggle value is sampled at ISSUE, so a flip during ACTIVE affects only the next packet.

Simultaneous events:
- hs_req and data_req in the same cycle → hs granted; data_req stays pending.
- A reset mid-packet returns to IDLE immediately with tx_packet=IDLE.
- Timer widths must hold the parameter values without wrap.

Optional Feature:
Macro USB_TX_RETRY_EN.
- Defined: a data packet ending with a latched tx_error, or a start timeout, is reissued once with the same toggle and size after a normal GAP. data_err pulses only if the retry also fails; no second grant pulse is issued. A pending hs_req still wins the arbitration ahead of the retry.
- Undefined: no retry; the first failure pulses data_err.

Test Plan:
- data_req=1, data_size=18, toggle=0; engine raises active 3 cycles after issue and holds it 40 cycles → data_grant, tx_packet=1 for 1 cycle, size=18, data_done on the fall, busy low 16 cycles after the fall.
- hs_req (pid=0) and data_req asserted in the same cycle → hs_grant first with tx_packet=3; data_grant 1 cycle after that packet's GAP ends.
- data_size=65 → data_err pulse, no grant, tx_packet stays 0, busy stays 0.
- Engine never asserts active → data_err at cycle 64 after issue; GAP; return to IDLE (with USB_TX_RETRY_EN: reissue, then data_err after the second timeout).
- ack_rcvd after a clean DATA0 → next data packet uses tx_packet=2; toggle_clr and ack_rcvd in the same cycle → data_toggle=0.
- n_rst=1 during ACTIVE → next cycle: IDLE, all outputs 0, data_toggle=0.
